pga_pot_writer: RTL and testbench



---
 rtl/pga_pot_writer.sv | 215 +++++++++++++++++++++
 tb/tb_pga_pot_writer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pga_pot_writer.sv
// pga_pot_writer: commits a PGA pot code and an HGA-bypass request to hardware.
// A change is sent to the pot as a 16-bit SPI mode-0 write {CMD_BYTE, code}, MSB first.
// Build option PGA_POT_WRITER_SEQ_EN: when defined, the bypass pin is moved before
// the write (on entering bypass) or after it (on leaving bypass), with a settle
// wait each time. When undefined, the pin takes the new value as chip select falls.
module pga_pot_writer #(
    parameter int         CLK_DIV       = 4,
    parameter int         SETTLE_CYCLES = 16,
    parameter logic [7:0] CMD_BYTE      = 8'h11
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] pga_code_i,
    input  logic       hga_bypass_i,
    output logic       sclk_o,
    output logic       cs_n_o,
    output logic       mosi_o,
    output logic       hga_bypass_o,
    output logic       busy_o,
    output logic       done_o
);

    // One down-counter times every phase, so it must hold the longer of the two loads.
    localparam int CNT_MAX = (SETTLE_CYCLES > CLK_DIV - 1) ? SETTLE_CYCLES : CLK_DIV - 1;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(CLK_DIV - 1);
`ifdef PGA_POT_WRITER_SEQ_EN
    // A bypass state lasts SETTLE_CYCLES + 1 cycles, the pin moving on its entry edge.
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);
`endif

    typedef enum logic [2:0] {
        IDLE,
        BYP_PRE,
        CS_SETUP,
        SHIFT_HI,
        SHIFT_LO,
        CS_HOLD,
        BYP_POST,
        GAP
    } state_t;

    state_t        r_state,   w_state;
    logic [CW-1:0] r_cnt,     w_cnt;
    logic [3:0]    r_bit,     w_bit;
    logic [15:0]   r_frame,   w_frame;
    logic          r_snapByp, w_snapByp;
    logic [8:0]    r_commit,  w_commit;
    logic          r_valid,   w_valid;
    logic          r_sclk,    w_sclk;
    logic          r_csN,     w_csN;
    logic          r_mosi,    w_mosi;
    logic          r_hga,     w_hga;
    logic          r_done,    w_done;
    logic [3:0]    w_bitDn;

    assign w_bitDn = r_bit - 4'd1;

    // Next-state and next-output decisions. Every output is a register, so the pins never glitch.
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt - CW'(1);
        w_bit     = r_bit;
        w_frame   = r_frame;
        w_snapByp = r_snapByp;
        w_commit  = r_commit;
        w_valid   = r_valid;
        w_sclk    = r_sclk;
        w_csN     = r_csN;
        w_mosi    = r_mosi;
        w_hga     = r_hga;
        w_done    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt = r_cnt;
                if (!r_valid || ({hga_bypass_i, pga_code_i} != r_commit)) begin
                    w_frame   = {CMD_BYTE, pga_code_i};
                    w_snapByp = hga_bypass_i;
`ifdef PGA_POT_WRITER_SEQ_EN
                    if (hga_bypass_i && !r_hga) begin
                        w_state = BYP_PRE;
                        w_hga   = 1'b1;
                        w_cnt   = SETTLE_LOAD;
                    end else begin
                        w_state = CS_SETUP;
                        w_csN   = 1'b0;
                        w_mosi  = CMD_BYTE[7];
                        w_cnt   = DIV_LOAD;
                    end
`else
                    w_state = CS_SETUP;
                    w_csN   = 1'b0;
                    w_mosi  = CMD_BYTE[7];
                    w_cnt   = DIV_LOAD;
                    w_hga   = hga_bypass_i;
`endif
                end
            end
            BYP_PRE: begin
                if (r_cnt == '0) begin
                    w_state = CS_SETUP;
                    w_csN   = 1'b0;
                    w_mosi  = r_frame[15];
                    w_cnt   = DIV_LOAD;
                end
            end
            CS_SETUP: begin
                if (r_cnt == '0) begin
                    w_state = SHIFT_HI;
                    w_sclk  = 1'b1;
                    w_bit   = 4'd15;
                    w_cnt   = DIV_LOAD;
                end
            end
            SHIFT_HI: begin
                if (r_cnt == '0) begin
                    w_sclk = 1'b0;
                    w_cnt  = DIV_LOAD;
                    if (r_bit == 4'd0) begin
                        w_state = CS_HOLD;
                    end else begin
                        w_state = SHIFT_LO;
                        w_bit   = w_bitDn;
                        w_mosi  = r_frame[w_bitDn];
                    end
                end
            end
            SHIFT_LO: begin
                if (r_cnt == '0) begin
                    w_state = SHIFT_HI;
                    w_sclk  = 1'b1;
                    w_cnt   = DIV_LOAD;
                end
            end
            CS_HOLD: begin
                if (r_cnt == '0) begin
                    w_csN  = 1'b1;
                    w_mosi = 1'b0;
`ifdef PGA_POT_WRITER_SEQ_EN
                    if (!r_snapByp && r_hga) begin
                        w_state = BYP_POST;
                        w_hga   = 1'b0;
                        w_cnt   = SETTLE_LOAD;
                    end else begin
                        w_state = GAP;
                        w_cnt   = DIV_LOAD;
                    end
`else
                    w_state = GAP;
                    w_cnt   = DIV_LOAD;
`endif
                end
            end
            BYP_POST: begin
                if (r_cnt == '0) begin
                    w_state = GAP;
                    w_cnt   = DIV_LOAD;
                end
            end
            GAP: begin
                if (r_cnt == CW'(1)) begin
                    w_done = 1'b1;
                end
                if (r_cnt == '0) begin
                    w_state  = IDLE;
                    w_commit = {r_snapByp, r_frame[7:0]};
                    w_valid  = 1'b1;
                end
            end
            default: begin
                w_state = IDLE;
                w_cnt   = '0;
            end
        endcase
    end

    // State and output registers; reset parks the pins idle with the HGA safely bypassed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit     <= 4'd0;
            r_frame   <= 16'h0000;
            r_snapByp <= 1'b1;
            r_commit  <= 9'h000;
            r_valid   <= 1'b0;
            r_sclk    <= 1'b0;
            r_csN     <= 1'b1;
            r_mosi    <= 1'b0;
            r_hga     <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_bit     <= w_bit;
            r_frame   <= w_frame;
            r_snapByp <= w_snapByp;
            r_commit  <= w_commit;
            r_valid   <= w_valid;
            r_sclk    <= w_sclk;
            r_csN     <= w_csN;
            r_mosi    <= w_mosi;
            r_hga     <= w_hga;
            r_done    <= w_done;
        end
    end

    assign sclk_o       = r_sclk;
    assign cs_n_o       = r_csN;
    assign mosi_o       = r_mosi;
    assign hga_bypass_o = r_hga;
    assign busy_o       = (r_state != IDLE);
    assign done_o       = r_done;

endmodule

// File: tb/tb_pga_pot_writer.sv
// tb_pga_pot_writer: drives pga_pot_writer with directed and random code/bypass
// requests and compares every pin, every cycle, against a timeline model built from
// the commit rules, plus an SPI decoder that rebuilds each frame from the pins.
module tb_pga_pot_writer;

    localparam int         D   = 4;
    localparam int         S   = 16;
    localparam logic [7:0] CMD = 8'h11;
`ifdef PGA_POT_WRITER_SEQ_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] pgaCode;
    logic       hgaBypass;
    logic       sclk, csN, mosi, hgaBypassOut, busy, done;

    int errorCount = 0;
    int checkCount = 0;

    // Timeline model: a sequence is a window of mLen busy cycles; pins follow from the offset.
    bit         mValid, mBusy, mPost, mHga;
    logic [8:0] mCommit, mSnap;
    int         mT, mLen, mPreLen, mCompleted;
    logic [5:0] expPins;
    logic [15:0] frameQ[$];

    // SPI decoder state.
    bit          prevSclk, prevCs;
    logic [15:0] spiShift;
    int          spiBits, csLowCount, doneSeen;

    pga_pot_writer #(.CLK_DIV(D), .SETTLE_CYCLES(S), .CMD_BYTE(CMD)) dut (
        .clk_i        (clock),
        .rst_i        (reset),
        .pga_code_i   (pgaCode),
        .hga_bypass_i (hgaBypass),
        .sclk_o       (sclk),
        .cs_n_o       (csN),
        .mosi_o       (mosi),
        .hga_bypass_o (hgaBypassOut),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Pins {busy, done, hga, cs_n, sclk, mosi} at offset mT inside the current window.
    function automatic logic [5:0] predictPins();
        logic        cs, sk, mo;
        logic [15:0] fr;
        int          u, phase, half;
        cs = 1'b1; sk = 1'b0; mo = 1'b0;
        if (mBusy) begin
            u = mT - 1 - mPreLen;
            if (u >= 0 && u < 33 * D) begin
                phase = u / D;
                half  = (phase / 2 > 15) ? 15 : phase / 2;
                fr    = {CMD, mSnap[7:0]};
                cs    = 1'b0;
                sk    = (phase % 2 == 1) && (phase <= 31);
                mo    = fr[15 - half];
            end
        end
        return {mBusy, mBusy && (mT == mLen), mHga, cs, sk, mo};
    endfunction

    task automatic resetModel();
        mValid = 1'b0; mBusy = 1'b0; mHga = 1'b1; mPost = 1'b0;
        mT = 0; mLen = 0; mPreLen = 0;
        frameQ.delete();
        spiBits = 0; csLowCount = 0; prevCs = 1'b1; prevSclk = 1'b0;
        expPins = predictPins();
    endtask

    // Advance the model across one rising edge with the inputs currently driven.
    task automatic stepModel(input logic [7:0] code, input logic byp);
        if (mBusy) begin
            if (mT == mLen) begin
                mBusy = 1'b0; mCommit = mSnap; mValid = 1'b1; mCompleted++;
            end else begin
                mT++;
                if (mPost && mT == mPreLen + 33 * D + 1) mHga = 1'b0;
            end
        end else if (!mValid || {byp, code} != mCommit) begin
            mBusy = 1'b1; mT = 1; mSnap = {byp, code};
            if (SEQ_EN) begin
                mPreLen = (byp && !mHga) ? S + 1 : 0;
                mPost   = !byp && mHga;
                if (byp) mHga = 1'b1;
            end else begin
                mPreLen = 0; mPost = 1'b0; mHga = byp;
            end
            mLen = 34 * D + mPreLen + (mPost ? S + 1 : 0);
            frameQ.push_back({CMD, code});
        end
        expPins = predictPins();
    endtask

    task automatic runCycle();
        if (reset) resetModel();
        else stepModel(pgaCode, hgaBypass);
        @(negedge clock);
        checkOutput("pins", 32'({busy, done, hgaBypassOut, csN, sclk, mosi}), 32'(expPins));
        if (done) doneSeen++;
        if (!csN) begin
            csLowCount++;
            if (sclk && !prevSclk) begin
                spiShift = {spiShift[14:0], mosi};
                spiBits++;
            end
        end
        if (csN && !prevCs) begin
            checkOutput("spiBits", 32'(spiBits), 32'd16);
            checkOutput("csLowCycles", 32'(csLowCount), 32'(33 * D));
            checkOutput("frameExpected", 32'(frameQ.size() != 0), 32'd1);
            if (frameQ.size() != 0) checkOutput("frame", 32'(spiShift), 32'(frameQ.pop_front()));
            spiBits = 0; csLowCount = 0;
        end
        prevSclk = sclk; prevCs = csN;
    endtask

    task automatic applyStimulus(input logic [7:0] code, input logic byp, input int cycles);
        pgaCode = code; hgaBypass = byp;
        repeat (cycles) runCycle();
    endtask

    initial begin
        logic [7:0] rc;
        logic       rb;
        reset = 1'b1; pgaCode = 8'h80; hgaBypass = 1'b1;
        mCompleted = 0; doneSeen = 0; spiShift = 16'h0000; mCommit = 9'h000; mSnap = 9'h000;
        resetModel();
        $display("[TB] reset and first forced frame");
        applyStimulus(8'h80, 1'b1, 3);
        reset = 1'b0;
        applyStimulus(8'h80, 1'b1, 200);
        $display("[TB] range crossovers");
        applyStimulus(8'hDC, 1'b1, 200);
        applyStimulus(8'h80, 1'b0, 260);
        applyStimulus(8'hDC, 1'b1, 260);
        $display("[TB] code change mid-frame");
        applyStimulus(8'h8D, 1'b1, 60);
        applyStimulus(8'h99, 1'b1, 350);
        $display("[TB] bypass-only change");
        applyStimulus(8'h99, 1'b0, 260);
        $display("[TB] reset during shift");
        applyStimulus(8'h42, 1'b1, 40);
        checkOutput("preRstCsLow", 32'(csN), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("rstCs", 32'(csN), 32'd1);
        checkOutput("rstSclk", 32'(sclk), 32'd0);
        checkOutput("rstMosi", 32'(mosi), 32'd0);
        checkOutput("rstHga", 32'(hgaBypassOut), 32'd1);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        resetModel();
        applyStimulus(8'h42, 1'b1, 3);
        reset = 1'b0;
        applyStimulus(8'h42, 1'b1, 200);
        $display("[TB] random requests");
        rc = 8'h42; rb = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (i % 5 == 4) rb = ~rb;
            else begin
                rc = 8'($urandom_range(0, 255));
                rb = 1'($urandom_range(0, 1));
            end
            applyStimulus(rc, rb, $urandom_range(1, 320));
        end
        applyStimulus(rc, rb, 400);
        checkOutput("doneCount", 32'(doneSeen), 32'(mCompleted));
        checkOutput("framesLeft", 32'(frameQ.size()), 32'd0);
        checkOutput("idleBusy", 32'(busy), 32'd0);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
